// File: rtl/kyber_ctrl_sequencer.sv
// Control/status register file for the Kyber polynomial core: decodes mode/start writes
// on the PS register port, sequences one core operation and arbitrates data-BRAM ownership.
module kyber_ctrl_sequencer #(
    parameter int          ADDR_W  = 13,
    parameter int          TIMEOUT = 200000,
    parameter logic [31:0] VERSION = 32'h0001_0000
) (
    input  logic              BRAM_PORTA_2_clk,
    input  logic              BRAM_PORTA_2_rst,
    input  logic              BRAM_PORTA_2_en,
    input  logic [3:0]        BRAM_PORTA_2_we,
    input  logic [ADDR_W-1:0] BRAM_PORTA_2_addr,
    input  logic [31:0]       BRAM_PORTA_2_din,
    output logic [31:0]       BRAM_PORTA_2_dout,
    output logic              core_start,
    output logic [1:0]        core_mode,
    input  logic              core_done,
    output logic              mem_owner,
    output logic              irq
);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;

    localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_MODE    = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_CYCLES  = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_VERSION = ADDR_W'(6);
    localparam logic [31:0]       TMO_LAST  = 32'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [31:0] ctrl_q;
    logic [1:0]  mode_q;
    logic [1:0]  core_mode_q;
    logic        done_q, mode_err_q, tmo_err_q;
    logic [31:0] cycles_q;
    logic        irq_q;
    logic [31:0] dout_q;
    logic [31:0] rdata;

    logic wr, start_req, mode_ok, timed_out, busy;
    logic enter_done, set_mode_err, set_tmo_err, do_launch;

    assign wr        = BRAM_PORTA_2_en && (|BRAM_PORTA_2_we);
    assign start_req = wr && (BRAM_PORTA_2_addr == A_CTRL) && BRAM_PORTA_2_din[0] && !ctrl_q[0];
    assign mode_ok   = (mode_q != 2'd3);
    assign timed_out = (TIMEOUT != 0) && (cycles_q == TMO_LAST);
    assign busy      = (state == LAUNCH) || (state == RUN);

    // Core handshake: core_start is a single-cycle request (valid) issued from LAUNCH; the
    // core answers with core_done (pulse or level), which is only honoured while in RUN.
    assign core_start = (state == LAUNCH);
    assign mem_owner  = busy;
    assign core_mode  = core_mode_q;
    assign irq        = irq_q;
    assign BRAM_PORTA_2_dout = dout_q;

    always_ff @(posedge BRAM_PORTA_2_clk) begin
        if (BRAM_PORTA_2_rst) state <= IDLE;
        else                  state <= state_next;
    end

    always_comb begin
        state_next   = state;
        enter_done   = 1'b0;
        set_mode_err = 1'b0;
        set_tmo_err  = 1'b0;
        do_launch    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start_req) begin
                    if (mode_ok) begin
                        state_next = LAUNCH;
                        do_launch  = 1'b1;
                    end else begin
                        state_next   = DONE;
                        enter_done   = 1'b1;
                        set_mode_err = 1'b1;
                    end
                end
            end
            LAUNCH: state_next = RUN;
            RUN: begin
                // A done arriving on the expiry cycle wins over the timeout.
                if (core_done) begin
                    state_next = DONE;
                    enter_done = 1'b1;
                end else if (timed_out) begin
                    state_next  = DONE;
                    enter_done  = 1'b1;
                    set_tmo_err = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge BRAM_PORTA_2_clk) begin
        if (BRAM_PORTA_2_rst) begin
            ctrl_q      <= '0;
            mode_q      <= '0;
            core_mode_q <= '0;
            done_q      <= 1'b0;
            mode_err_q  <= 1'b0;
            tmo_err_q   <= 1'b0;
            cycles_q    <= '0;
            irq_q       <= 1'b0;
        end else begin
            if (wr && BRAM_PORTA_2_addr == A_CTRL) ctrl_q <= BRAM_PORTA_2_din;
            if (wr && BRAM_PORTA_2_addr == A_MODE) mode_q <= BRAM_PORTA_2_din[1:0];
            irq_q <= enter_done;
            if (do_launch) begin
                core_mode_q <= mode_q;
                done_q      <= 1'b0;
                mode_err_q  <= 1'b0;
                tmo_err_q   <= 1'b0;
                cycles_q    <= '0;
            end else if (state == RUN && cycles_q != 32'hFFFF_FFFF) begin
                cycles_q <= cycles_q + 32'd1;
            end
            if (enter_done) begin
                done_q     <= 1'b1;
                mode_err_q <= set_mode_err;
                tmo_err_q  <= set_tmo_err;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (BRAM_PORTA_2_addr)
            A_CTRL:    rdata = ctrl_q;
            A_MODE:    rdata = {30'd0, mode_q};
            A_STATUS:  rdata = {28'd0, busy, tmo_err_q, mode_err_q, done_q};
            A_CYCLES:  rdata = cycles_q;
            A_VERSION: rdata = VERSION;
            default:   rdata = '0;
        endcase
    end

    // Read-first: rdata is sampled from the pre-write register contents.
    always_ff @(posedge BRAM_PORTA_2_clk) begin
        if (BRAM_PORTA_2_rst)     dout_q <= '0;
        else if (BRAM_PORTA_2_en) dout_q <= rdata;
    end

endmodule

// File: tb/tb_kyber_ctrl_sequencer.sv
// Bench for kyber_ctrl_sequencer: one default-timeout instance (a) and one TIMEOUT=16
// instance (b) share the register bus and core_done; results are checked against a rule model.
module tb_kyber_ctrl_sequencer;

    localparam logic [12:0] A_CTRL    = 13'd1;
    localparam logic [12:0] A_MODE    = 13'd3;
    localparam logic [12:0] A_STATUS  = 13'd4;
    localparam logic [12:0] A_CYCLES  = 13'd5;
    localparam logic [12:0] A_VERSION = 13'd6;
    localparam int TMO_A = 200000;
    localparam int TMO_B = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  we = 4'd0;
    logic [12:0] addr = '0;
    logic [31:0] din = '0;
    logic        core_done = 1'b0;
    logic [31:0] dout_a, dout_b;
    logic        core_start_a, core_start_b, mem_owner_a, mem_owner_b, irq_a, irq_b;
    logic [1:0]  core_mode_a, core_mode_b;

    int total = 0;
    int bad = 0;
    int start_cnt_a = 0, start_cnt_b = 0, irq_cnt_a = 0, irq_cnt_b = 0;

    kyber_ctrl_sequencer #(.TIMEOUT(TMO_A)) dut_a (
        .BRAM_PORTA_2_clk(clk), .BRAM_PORTA_2_rst(rst), .BRAM_PORTA_2_en(en),
        .BRAM_PORTA_2_we(we), .BRAM_PORTA_2_addr(addr), .BRAM_PORTA_2_din(din),
        .BRAM_PORTA_2_dout(dout_a), .core_start(core_start_a), .core_mode(core_mode_a),
        .core_done(core_done), .mem_owner(mem_owner_a), .irq(irq_a)
    );

    kyber_ctrl_sequencer #(.TIMEOUT(TMO_B)) dut_b (
        .BRAM_PORTA_2_clk(clk), .BRAM_PORTA_2_rst(rst), .BRAM_PORTA_2_en(en),
        .BRAM_PORTA_2_we(we), .BRAM_PORTA_2_addr(addr), .BRAM_PORTA_2_din(din),
        .BRAM_PORTA_2_dout(dout_b), .core_start(core_start_b), .core_mode(core_mode_b),
        .core_done(core_done), .mem_owner(mem_owner_b), .irq(irq_b)
    );

    // clock / reset / event counters
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (core_start_a) start_cnt_a++;
        if (core_start_b) start_cnt_b++;
        if (irq_a) irq_cnt_a++;
        if (irq_b) irq_cnt_b++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // reference model: outcome of one operation whose core_done arrives after `delay` RUN cycles
    function automatic logic [31:0] exp_status(input int delay, input int tmo);
        if (tmo != 0 && delay > tmo) return 32'h5;
        return 32'h1;
    endfunction

    function automatic logic [31:0] exp_cycles(input int delay, input int tmo);
        if (tmo != 0 && delay > tmo) return 32'(tmo);
        return 32'(delay);
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [12:0] a, input logic [31:0] d);
        en = 1'b1; we = 4'($urandom_range(1, 15)); addr = a; din = d;
        tick();
        en = 1'b0; we = 4'd0;
    endtask

    task automatic read_reg(input logic [12:0] a, output logic [31:0] ra, output logic [31:0] rb);
        en = 1'b1; we = 4'd0; addr = a;
        tick();
        en = 1'b0;
        ra = dout_a; rb = dout_b;
    endtask

    task automatic run_op(input logic [1:0] mode, input int delay, input bit check_busy);
        int sa0, sb0, ia0, ib0, t;
        bit hold_ok;
        logic [31:0] ra, rb;
        sa0 = start_cnt_a; sb0 = start_cnt_b; ia0 = irq_cnt_a; ib0 = irq_cnt_b;
        write_reg(A_MODE, {30'd0, mode});
        write_reg(A_CTRL, 32'd0);
        write_reg(A_CTRL, 32'd1);
        total++;
        if (core_start_a !== 1'b1 || mem_owner_a !== 1'b1) begin
            bad++; $display("FAIL launch got=start%b/owner%b exp=1/1", core_start_a, mem_owner_a);
        end
        total++;
        if (core_mode_a !== mode) begin
            bad++; $display("FAIL core_mode got=%0d exp=%0d", core_mode_a, mode);
        end
        t = 0;
        hold_ok = 1'b1;
        while (t < delay) begin
            if (check_busy && t == 1) begin
                read_reg(A_STATUS, ra, rb);
                t++;
                total++;
                if (ra !== 32'h8) begin
                    bad++; $display("FAIL busy_status got=%h exp=%h", ra, 32'h8);
                end
            end else begin
                tick();
                t++;
            end
            if (t < delay && (core_start_a !== 1'b0 || mem_owner_a !== 1'b1 || core_mode_a !== mode))
                hold_ok = 1'b0;
        end
        total++;
        if (!hold_ok) begin
            bad++; $display("FAIL run_hold got=changed exp=start0_owner1_mode%0d", mode);
        end
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        total++;
        if (irq_a !== 1'b1 || mem_owner_a !== 1'b0) begin
            bad++; $display("FAIL done_entry got=irq%b/owner%b exp=1/0", irq_a, mem_owner_a);
        end
        read_reg(A_STATUS, ra, rb);
        total++;
        if (ra !== exp_status(delay, TMO_A)) begin
            bad++; $display("FAIL status_a got=%h exp=%h", ra, exp_status(delay, TMO_A));
        end
        total++;
        if (rb !== exp_status(delay, TMO_B)) begin
            bad++; $display("FAIL status_b got=%h exp=%h", rb, exp_status(delay, TMO_B));
        end
        read_reg(A_CYCLES, ra, rb);
        total++;
        if (ra !== exp_cycles(delay, TMO_A)) begin
            bad++; $display("FAIL cycles_a got=%0d exp=%0d", ra, exp_cycles(delay, TMO_A));
        end
        total++;
        if (rb !== exp_cycles(delay, TMO_B)) begin
            bad++; $display("FAIL cycles_b got=%0d exp=%0d", rb, exp_cycles(delay, TMO_B));
        end
        total++;
        if (start_cnt_a - sa0 !== 1 || start_cnt_b - sb0 !== 1) begin
            bad++; $display("FAIL start_count got=%0d/%0d exp=1/1", start_cnt_a - sa0, start_cnt_b - sb0);
        end
        total++;
        if (irq_cnt_a - ia0 !== 1 || irq_cnt_b - ib0 !== 1) begin
            bad++; $display("FAIL irq_count got=%0d/%0d exp=1/1", irq_cnt_a - ia0, irq_cnt_b - ib0);
        end
    endtask

    // scenarios
    task automatic test_reset();
        logic [31:0] ra, rb;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        total++;
        if ({core_start_a, mem_owner_a, irq_a, core_mode_a, core_start_b, mem_owner_b, irq_b} !== 9'd0
            || dout_a !== 32'd0) begin
            bad++; $display("FAIL reset_outputs got=%b/%h exp=0/0",
                {core_start_a, mem_owner_a, irq_a, core_mode_a}, dout_a);
        end
        read_reg(A_VERSION, ra, rb);
        total++;
        if (ra !== 32'h0001_0000) begin
            bad++; $display("FAIL version got=%h exp=%h", ra, 32'h0001_0000);
        end
        read_reg(A_STATUS, ra, rb);
        total++;
        if (ra !== 32'd0 || rb !== 32'd0) begin
            bad++; $display("FAIL reset_status got=%h/%h exp=0/0", ra, rb);
        end
    endtask

    task automatic test_basic();
        logic [31:0] held;
        run_op(2'd0, 40, 1'b1);
        held = dout_a;
        repeat (3) tick();
        total++;
        if (dout_a !== held) begin
            bad++; $display("FAIL dout_hold got=%h exp=%h", dout_a, held);
        end
    endtask

    task automatic test_back_to_back();
        run_op(2'd1, $urandom_range(5, 30), 1'b1);
        run_op(2'd2, $urandom_range(5, 30), 1'b1);
    endtask

    task automatic test_mode_err();
        int sa0, ia0;
        logic [31:0] ra, rb;
        sa0 = start_cnt_a; ia0 = irq_cnt_a;
        write_reg(A_MODE, 32'd3);
        total++;
        if (dout_a !== 32'd2) begin
            bad++; $display("FAIL read_first got=%h exp=%h", dout_a, 32'd2);
        end
        write_reg(A_CTRL, 32'd0);
        write_reg(A_CTRL, 32'd1);
        total++;
        if (core_start_a !== 1'b0 || mem_owner_a !== 1'b0 || irq_a !== 1'b1) begin
            bad++; $display("FAIL mode_err_entry got=%b%b%b exp=001", core_start_a, mem_owner_a, irq_a);
        end
        read_reg(A_STATUS, ra, rb);
        total++;
        if (ra !== 32'h3 || rb !== 32'h3) begin
            bad++; $display("FAIL mode_err_status got=%h/%h exp=3/3", ra, rb);
        end
        total++;
        if (start_cnt_a != sa0 || irq_cnt_a - ia0 != 1) begin
            bad++; $display("FAIL mode_err_counts got=%0d/%0d exp=0/1", start_cnt_a - sa0, irq_cnt_a - ia0);
        end
    endtask

    task automatic test_timeout();
        run_op(2'd0, TMO_B, 1'b0);
        run_op(2'd1, TMO_B + 1, 1'b0);
        for (int i = 0; i < 4; i++)
            run_op(2'($urandom_range(0, 2)), $urandom_range(1, 24), 1'($urandom_range(0, 1)));
    endtask

    task automatic test_ignored_writes();
        int sa0;
        logic [31:0] ra, rb;
        write_reg(13'h3F, 32'h00AD_BEEF ^ 32'($urandom_range(0, 255)));
        read_reg(13'h3F, ra, rb);
        total++;
        if (ra !== 32'd0) begin
            bad++; $display("FAIL unmapped_read got=%h exp=0", ra);
        end
        sa0 = start_cnt_a;
        write_reg(A_MODE, 32'd1);
        write_reg(A_CTRL, 32'd0);
        write_reg(A_CTRL, 32'd1);
        total++;
        if (core_start_a !== 1'b1) begin
            bad++; $display("FAIL ign_launch got=%b exp=1", core_start_a);
        end
        write_reg(A_CTRL, 32'd1);
        write_reg(13'h1003, 32'd0);
        write_reg(A_MODE, 32'd2);
        read_reg(A_MODE, ra, rb);
        total++;
        if (ra !== 32'd2 || core_mode_a !== 2'd1) begin
            bad++; $display("FAIL mode_during_run got=reg%h/latched%0d exp=2/1", ra, core_mode_a);
        end
        repeat (3) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        read_reg(A_STATUS, ra, rb);
        total++;
        if (ra !== 32'h1 || rb !== 32'h1) begin
            bad++; $display("FAIL ign_status got=%h/%h exp=1/1", ra, rb);
        end
        total++;
        if (start_cnt_a - sa0 != 1) begin
            bad++; $display("FAIL single_launch got=%0d exp=1", start_cnt_a - sa0);
        end
    endtask

    task automatic test_reset_mid_run();
        int sa0, sb0;
        logic [31:0] ra, rb;
        write_reg(A_MODE, 32'($urandom_range(1, 2)));
        write_reg(A_CTRL, 32'd0);
        write_reg(A_CTRL, 32'd1);
        repeat ($urandom_range(3, 8)) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({core_start_a, mem_owner_a, irq_a, core_mode_a} !== 5'd0 || dout_a !== 32'd0
            || {core_start_b, mem_owner_b, irq_b, core_mode_b} !== 5'd0) begin
            bad++; $display("FAIL mid_run_reset got=%b/%h exp=0/0",
                {core_start_a, mem_owner_a, irq_a, core_mode_a}, dout_a);
        end
        sa0 = start_cnt_a; sb0 = start_cnt_b;
        repeat (2) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        repeat (2) tick();
        read_reg(A_STATUS, ra, rb);
        total++;
        if (ra !== 32'd0 || rb !== 32'd0 || mem_owner_a !== 1'b0) begin
            bad++; $display("FAIL post_reset_status got=%h/%h exp=0/0", ra, rb);
        end
        read_reg(A_CTRL, ra, rb);
        total++;
        if (ra !== 32'd0 || start_cnt_a != sa0 || start_cnt_b != sb0) begin
            bad++; $display("FAIL post_reset_ctrl got=%h/%0d exp=0/0", ra, start_cnt_a - sa0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_mode_err();
        test_timeout();
        test_ignored_writes();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
